fetch_ctrl: RTL

//  Program-counter / fetch-control stage that feeds the decode and execute logic built on the shared op_mne opcode set.

---
 rtl/fetch_ctrl_pkg.sv | 40 ++++
 rtl/fetch_ctrl_branch_lut.sv | 32 +++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared opcode set, fetch FSM states and instruction field widths for the
// fetch/decode/execute slice.
package fetch_ctrl_pkg;

    localparam int INSTR_W = 9;
    localparam int OPND_W  = 5;

    localparam logic [1:0] JMP_PREFIX = 2'b11;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        MOV = 4'b0010,
        AND = 4'b0011,
        OR  = 4'b0100,
        XOR = 4'b0101,
        SHL = 4'b0110,
        BEQ = 4'b0111,
        BNE = 4'b1000,
        BGE = 4'b1001,
        LW  = 4'b1010,
        SW  = 4'b1011,
        JMP = 4'b1100
    } op_mne;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        MEMWAIT,
        DONE
    } fetch_state_e;

    // Any instruction carrying the 2-bit jump prefix is a JMP, so 4'b1100-4'b1111 all alias to it.
    function automatic op_mne decode_op(input logic [INSTR_W-1:0] instr);
        if (instr[INSTR_W-1:INSTR_W-2] == JMP_PREFIX)
            return JMP;
        return op_mne'(instr[INSTR_W-1:OPND_W]);
    endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch/jump target table indexed by the 5-bit operand.
// Entries at or beyond LUT_DEPTH read as zero.
module branch_lut
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32
) (
    input  logic [OPND_W-1:0] idx,
    output logic [PC_W-1:0]   target
);

    always_comb begin
        target = '0;
        if (int'(idx) < LUT_DEPTH) begin
            case (idx)
                5'd0:    target = PC_W'(12);
                5'd1:    target = PC_W'(7);
                5'd2:    target = PC_W'(16);
                5'd3:    target = PC_W'(40);
                5'd4:    target = PC_W'(5);
                5'd5:    target = PC_W'(100);
                5'd6:    target = PC_W'(1023);
                5'd7:    target = PC_W'(9);
                5'd8:    target = PC_W'(0);
                5'd9:    target = PC_W'(20);
                default: target = PC_W'({idx, 2'b00}) + PC_W'(200);
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch control: IDLE/RUN/MEMWAIT/DONE FSM, combinational decode, next-PC mux.
// FETCH_PERF_EN adds saturating cycle and committed-instruction counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int START_PC  = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               cmp_eq_i,
    input  logic               cmp_ge_i,
    input  logic               mem_done_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [3:0]         opcode_o,
    output logic [OPND_W-1:0]  operand_o,
    output logic               ir_valid_o,
    output logic               done_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        cyc_cnt_o,
    output logic [15:0]        instr_cnt_o
`endif
);

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_inc, target;
    op_mne           op;

    assign op        = decode_op(instr_i);
    assign opcode_o  = op;
    assign operand_o = instr_i[OPND_W-1:0];
    assign pc_o      = pc;
    assign pc_inc    = pc + PC_W'(1);

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .idx    (instr_i[OPND_W-1:0]),
        .target (target)
    );

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_valid_o = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    pc_nxt    = PC_W'(START_PC);
                end
            end
            RUN: begin
                ir_valid_o = 1'b1;
                pc_nxt     = pc_inc;
                case (op)
                    BEQ: if (cmp_eq_i)  pc_nxt = target;
                    BNE: if (!cmp_eq_i) pc_nxt = target;
                    BGE: if (cmp_ge_i)  pc_nxt = target;
                    JMP: begin
                        // A jump onto itself is the program's halt idiom.
                        if (target == pc) begin
                            state_nxt = DONE;
                            pc_nxt    = pc;
                        end else begin
                            pc_nxt = target;
                        end
                    end
                    LW, SW: begin
                        if (!mem_done_i) begin
                            state_nxt = MEMWAIT;
                            pc_nxt    = pc;
                        end
                    end
                    default: ;
                endcase
            end
            MEMWAIT: begin
                if (mem_done_i) begin
                    state_nxt = RUN;
                    pc_nxt    = pc_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            pc     <= PC_W'(START_PC);
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            done_o <= (state_nxt == DONE);
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] cyc_cnt, instr_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if ((state == IDLE || state == DONE) && start_i) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (state == RUN || state == MEMWAIT) begin
            if (cyc_cnt != 16'hFFFF)
                cyc_cnt <= cyc_cnt + 16'd1;
            if (ir_valid_o && instr_cnt != 16'hFFFF)
                instr_cnt <= instr_cnt + 16'd1;
        end
    end

    assign cyc_cnt_o   = cyc_cnt;
    assign instr_cnt_o = instr_cnt;
`endif

endmodule
